cvw_arch_verif_monitor: RTL and testbench

Single-hart, single-retire RVVI trace coverage monitor. It samples one retired-instruction record per clock and keeps saturating event counters (bins) and sticky register-write bitmaps. A select port reads any bin. It sits beside the RVVI trace source (trace replayer or core) and gives functional-coverage and order-consistency results for architectural verification runs.

---
 rtl/cvw_arch_verif_monitor.sv | 185 ++++++++++++++++++
 tb/tb_cvw_arch_verif_monitor.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cvw_arch_verif_monitor.sv
// ---------------------------------------------------------------------------
// cvw_arch_verif_monitor
//
// Single-hart, single-retire RVVI trace coverage monitor. One retired
// instruction record is sampled per clock when valid is high. Each record
// bumps a set of saturating event counters (bins 0..52) and ORs its
// register write-back strobes into sticky bitmaps. It also checks that
// retirement order numbers advance by exactly one.
//
// Ports:
//   clk, reset            clock, synchronous active-high reset
//   valid                 trace record present this cycle
//   order                 64-bit retirement sequence number
//   insn                  instruction word
//   trap, debug_mode      trap / debug-mode flags
//   pc_rdata              PC of the retiring instruction
//   mode                  privilege mode (0 U, 1 S, 3 M)
//   m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr   interrupt pending flags
//   read_access, write_access, execute_access           memory access kinds
//   page_type_d           data-side page type
//   x_wb, f_wb, v_wb      per-register write-back strobes
//   cov_sel               bin index to read
//   cov_count             value of bin cov_sel (0 for reserved bins 53..63)
//   x_seen, f_seen, v_seen sticky OR of write-back strobes
//   bins_hit              number of bins 0..51 with a nonzero count
//   order_err             one-cycle pulse after an order discontinuity
//
// Bin map:
//   0 retired, 1 trap, 2..5 mode 0..3, 6 debug_mode, 7 m_ext_intr,
//   8 s_ext_intr, 9 m_timer_intr, 10 m_soft_intr, 11 read, 12 write,
//   13 execute, 14 compressed, 15 order errors, 16..47 major opcode of
//   uncompressed insns, 48..51 page_type_d on data accesses, 52 pc_rdata[1].
// ---------------------------------------------------------------------------
module cvw_arch_verif_monitor #(
    parameter int XLEN = 64,
    parameter int CNTW = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              valid,
    input  logic [63:0]       order,
    input  logic [31:0]       insn,
    input  logic              trap,
    input  logic              debug_mode,
    input  logic [XLEN-1:0]   pc_rdata,
    input  logic [1:0]        mode,
    input  logic              m_ext_intr,
    input  logic              s_ext_intr,
    input  logic              m_timer_intr,
    input  logic              m_soft_intr,
    input  logic              read_access,
    input  logic              write_access,
    input  logic              execute_access,
    input  logic [1:0]        page_type_d,
    input  logic [31:0]       x_wb,
    input  logic [31:0]       f_wb,
    input  logic [31:0]       v_wb,
    input  logic [5:0]        cov_sel,
    output logic [CNTW-1:0]   cov_count,
    output logic [31:0]       x_seen,
    output logic [31:0]       f_seen,
    output logic [31:0]       v_seen,
    output logic [6:0]        bins_hit,
    output logic              order_err
);

    localparam int NBINS = 53;

    // Counter increment that sticks at all-ones instead of wrapping.
    function automatic logic [CNTW-1:0] sat_inc(input logic [CNTW-1:0] v);
        if (v == {CNTW{1'b1}}) begin
            return v;
        end else begin
            return v + {{(CNTW-1){1'b0}}, 1'b1};
        end
    endfunction

    logic [CNTW-1:0] r_bins [0:NBINS-1];
    logic [31:0]     r_x_seen;
    logic [31:0]     r_f_seen;
    logic [31:0]     r_v_seen;
    logic            r_order_err;
    logic            r_first_seen;
    logic [63:0]     r_prev_order;

    logic [NBINS-1:0] w_inc;
    logic             w_order_bad;
    logic             w_uncompressed;
    logic             w_data_access;
    logic [CNTW-1:0]  w_cov_count;
    logic [6:0]       w_bins_hit;
    logic             w_unused;

    // Only pc_rdata[1] and the opcode field of insn feed any bin.
    assign w_unused = ^{insn[31:7], pc_rdata[XLEN-1:2], pc_rdata[0]};

    assign w_uncompressed = (insn[1:0] == 2'b11);
    assign w_data_access  = read_access | write_access;
    // The very first record after reset has nothing to compare against.
    assign w_order_bad    = r_first_seen && (order != (r_prev_order + 64'd1));

    // Which bins this record hits; several may be set at once.
    always_comb begin
        w_inc     = {NBINS{1'b0}};
        w_inc[0]  = 1'b1;
        w_inc[1]  = trap;
        for (int k = 0; k < 4; k++) begin
            w_inc[2 + k]  = (mode == 2'(k));
            w_inc[48 + k] = w_data_access && (page_type_d == 2'(k));
        end
        w_inc[6]  = debug_mode;
        w_inc[7]  = m_ext_intr;
        w_inc[8]  = s_ext_intr;
        w_inc[9]  = m_timer_intr;
        w_inc[10] = m_soft_intr;
        w_inc[11] = read_access;
        w_inc[12] = write_access;
        w_inc[13] = execute_access;
        w_inc[14] = !w_uncompressed;
        w_inc[15] = w_order_bad;
        for (int k = 0; k < 32; k++) begin
            w_inc[16 + k] = w_uncompressed && (insn[6:2] == 5'(k));
        end
        w_inc[52] = pc_rdata[1];
    end

    // Bin counters, sticky bitmaps and order tracking.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NBINS; i++) begin
                r_bins[i] <= {CNTW{1'b0}};
            end
            r_x_seen     <= 32'd0;
            r_f_seen     <= 32'd0;
            r_v_seen     <= 32'd0;
            r_order_err  <= 1'b0;
            r_first_seen <= 1'b0;
            r_prev_order <= 64'd0;
        end else if (valid) begin
            for (int i = 0; i < NBINS; i++) begin
                if (w_inc[i]) begin
                    r_bins[i] <= sat_inc(r_bins[i]);
                end else begin
                    r_bins[i] <= r_bins[i];
                end
            end
            r_x_seen     <= r_x_seen | x_wb;
            r_f_seen     <= r_f_seen | f_wb;
            r_v_seen     <= r_v_seen | v_wb;
            r_order_err  <= w_order_bad;
            r_first_seen <= 1'b1;
            r_prev_order <= order;
        end else begin
            r_order_err  <= 1'b0;
        end
    end

    // Bin read mux; reserved indices read as zero.
    always_comb begin
        w_cov_count = {CNTW{1'b0}};
        for (int i = 0; i < NBINS; i++) begin
            if (cov_sel == 6'(i)) begin
                w_cov_count = r_bins[i];
            end else begin
                w_cov_count = w_cov_count;
            end
        end
    end

    // Popcount of nonzero bins; bin 52 is deliberately excluded.
    always_comb begin
        w_bins_hit = 7'd0;
        for (int i = 0; i < 52; i++) begin
            w_bins_hit = w_bins_hit + {6'd0, (r_bins[i] != {CNTW{1'b0}})};
        end
    end

    assign cov_count = w_cov_count;
    assign bins_hit  = w_bins_hit;
    assign x_seen    = r_x_seen;
    assign f_seen    = r_f_seen;
    assign v_seen    = r_v_seen;
    assign order_err = r_order_err;

endmodule

// File: tb/tb_cvw_arch_verif_monitor.sv
// ---------------------------------------------------------------------------
// Testbench for cvw_arch_verif_monitor. A main instance (CNTW=32) and a
// narrow instance (CNTW=4) share all inputs. A reference model of the bins
// and bitmaps is updated whenever a record is driven; the expected order_err
// for each cycle is queued then and popped after the clock edge.
// ---------------------------------------------------------------------------
module tb_cvw_arch_verif_monitor;

    logic        clk = 1'b0;
    logic        reset, valid, trap, debug_mode;
    logic [63:0] order;
    logic [31:0] insn;
    logic [63:0] pc_rdata;
    logic [1:0]  mode, page_type_d;
    logic        m_ext_intr, s_ext_intr, m_timer_intr, m_soft_intr;
    logic        read_access, write_access, execute_access;
    logic [31:0] x_wb, f_wb, v_wb;
    logic [5:0]  cov_sel;
    logic [31:0] cov_count, x_seen, f_seen, v_seen;
    logic [6:0]  bins_hit;
    logic        order_err;
    logic [3:0]  s_cov_count;
    logic [31:0] s_x_seen, s_f_seen, s_v_seen;
    logic [6:0]  s_bins_hit;
    logic        s_order_err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] m_bins [0:52];
    logic [31:0] m_x, m_f, m_v;
    logic        m_first;
    logic [63:0] m_prev;
    int          m_small;
    logic        q_err [$];

    always #5 clk = ~clk;

    cvw_arch_verif_monitor #(.XLEN(64), .CNTW(32)) u_dut (
        .clk(clk), .reset(reset), .valid(valid), .order(order), .insn(insn),
        .trap(trap), .debug_mode(debug_mode), .pc_rdata(pc_rdata), .mode(mode),
        .m_ext_intr(m_ext_intr), .s_ext_intr(s_ext_intr),
        .m_timer_intr(m_timer_intr), .m_soft_intr(m_soft_intr),
        .read_access(read_access), .write_access(write_access),
        .execute_access(execute_access), .page_type_d(page_type_d),
        .x_wb(x_wb), .f_wb(f_wb), .v_wb(v_wb), .cov_sel(cov_sel),
        .cov_count(cov_count), .x_seen(x_seen), .f_seen(f_seen),
        .v_seen(v_seen), .bins_hit(bins_hit), .order_err(order_err)
    );

    cvw_arch_verif_monitor #(.XLEN(64), .CNTW(4)) u_small (
        .clk(clk), .reset(reset), .valid(valid), .order(order), .insn(insn),
        .trap(trap), .debug_mode(debug_mode), .pc_rdata(pc_rdata), .mode(mode),
        .m_ext_intr(m_ext_intr), .s_ext_intr(s_ext_intr),
        .m_timer_intr(m_timer_intr), .m_soft_intr(m_soft_intr),
        .read_access(read_access), .write_access(write_access),
        .execute_access(execute_access), .page_type_d(page_type_d),
        .x_wb(x_wb), .f_wb(f_wb), .v_wb(v_wb), .cov_sel(cov_sel),
        .cov_count(s_cov_count), .x_seen(s_x_seen), .f_seen(s_f_seen),
        .v_seen(s_v_seen), .bins_hit(s_bins_hit), .order_err(s_order_err)
    );

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic clear_rec();
        trap = 1'b0; debug_mode = 1'b0; pc_rdata = 64'd0; mode = 2'd3;
        m_ext_intr = 1'b0; s_ext_intr = 1'b0; m_timer_intr = 1'b0; m_soft_intr = 1'b0;
        read_access = 1'b0; write_access = 1'b0; execute_access = 1'b0;
        page_type_d = 2'd0; x_wb = 32'd0; f_wb = 32'd0; v_wb = 32'd0;
        insn = 32'h0000_0013; order = 64'd0;
    endtask

    task automatic model_reset();
        for (int i = 0; i < 53; i++) m_bins[i] = 32'd0;
        m_x = 32'd0; m_f = 32'd0; m_v = 32'd0;
        m_first = 1'b0; m_prev = 64'd0; m_small = 0;
    endtask

    function automatic void m_inc(input int idx);
        if (m_bins[idx] != 32'hFFFF_FFFF) m_bins[idx] = m_bins[idx] + 32'd1;
    endfunction

    task automatic pop_check();
        logic e;
        check_val("sb_depth", 64'(q_err.size()), 64'd1);
        if (q_err.size() != 0) begin
            e = q_err.pop_front();
            check_val("order_err", {63'd0, order_err}, {63'd0, e});
        end
    endtask

    // Drive the current record for one cycle, updating the model alongside.
    task automatic send();
        logic err;
        valid = 1'b1;
        err = m_first && (order != m_prev + 64'd1);
        m_inc(0);
        if (trap) m_inc(1);
        m_inc(2 + int'(mode));
        if (debug_mode) m_inc(6);
        if (m_ext_intr) m_inc(7);
        if (s_ext_intr) m_inc(8);
        if (m_timer_intr) m_inc(9);
        if (m_soft_intr) m_inc(10);
        if (read_access) m_inc(11);
        if (write_access) m_inc(12);
        if (execute_access) m_inc(13);
        if (insn[1:0] != 2'b11) m_inc(14);
        else m_inc(16 + int'(insn[6:2]));
        if (err) m_inc(15);
        if (read_access || write_access) m_inc(48 + int'(page_type_d));
        if (pc_rdata[1]) m_inc(52);
        m_x = m_x | x_wb; m_f = m_f | f_wb; m_v = m_v | v_wb;
        m_first = 1'b1; m_prev = order;
        if (m_small < 15) m_small++;
        q_err.push_back(err);
        @(posedge clk); #1;
        valid = 1'b0;
        pop_check();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            valid = 1'b0;
            q_err.push_back(1'b0);
            @(posedge clk); #1;
            pop_check();
        end
    endtask

    task automatic do_reset(input logic with_valid);
        valid = with_valid;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        valid = 1'b0;
        model_reset();
        check_val("rst_order_err", {63'd0, order_err}, 64'd0);
    endtask

    task automatic chk_bin(input string tag, input int idx, input logic [31:0] exp);
        cov_sel = 6'(idx);
        #1;
        check_val(tag, {32'd0, cov_count}, {32'd0, exp});
    endtask

    task automatic chk_all();
        int hits;
        hits = 0;
        for (int i = 0; i < 64; i++) begin
            cov_sel = 6'(i);
            #1;
            check_val($sformatf("bin%0d", i), {32'd0, cov_count},
                      {32'd0, (i < 53) ? m_bins[i] : 32'd0});
        end
        for (int i = 0; i < 52; i++) if (m_bins[i] != 32'd0) hits++;
        check_val("bins_hit", {57'd0, bins_hit}, 64'(hits));
        check_val("x_seen", {32'd0, x_seen}, {32'd0, m_x});
        check_val("f_seen", {32'd0, f_seen}, {32'd0, m_f});
        check_val("v_seen", {32'd0, v_seen}, {32'd0, m_v});
    endtask

    initial begin
        reset = 1'b0; valid = 1'b0; cov_sel = 6'd0;
        clear_rec();
        model_reset();
        @(posedge clk); #1;

        // Reset with a record present: the record must be discarded.
        x_wb = 32'hFFFF_FFFF; order = 64'd77;
        do_reset(1'b1);
        clear_rec();
        chk_all();
        chk_bin("rst_bin0", 0, 32'd0);

        // Three sequential addi records in M mode.
        for (int i = 1; i <= 3; i++) begin
            order = 64'(i);
            send();
        end
        chk_bin("seq_bin0", 0, 32'd3);
        chk_bin("seq_bin5", 5, 32'd3);
        chk_bin("seq_bin20", 20, 32'd3);
        chk_bin("seq_bin15", 15, 32'd0);
        check_val("seq_bins_hit", {57'd0, bins_hit}, 64'd3);

        // Compressed instruction with a write to x10.
        order = 64'd4; insn = 32'h0000_4501; x_wb = 32'h0000_0400;
        send();
        chk_bin("c_bin14", 14, 32'd1);
        chk_bin("c_bin16", 16, 32'd0);
        chk_bin("c_bin20", 20, 32'd3);
        check_val("c_x_seen", {32'd0, x_seen}, 64'h400);
        chk_all();

        // Order sequence 1,2,5,6: single-cycle error pulse at 5.
        do_reset(1'b0);
        clear_rec();
        order = 64'd1; send();
        order = 64'd2; send();
        order = 64'd5; send();
        order = 64'd6; send();
        idle(2);
        chk_bin("ord_bin15", 15, 32'd1);

        // Trapped ecall in U mode with a timer interrupt pending.
        clear_rec();
        order = 64'd7; trap = 1'b1; mode = 2'd0; m_timer_intr = 1'b1;
        insn = 32'h0000_0073;
        send();
        chk_bin("trap_bin1", 1, 32'd1);
        chk_bin("trap_bin2", 2, 32'd1);
        chk_bin("trap_bin9", 9, 32'd1);
        chk_bin("trap_bin44", 44, 32'd1);

        // Page type counted only on data accesses.
        clear_rec();
        order = 64'd8; write_access = 1'b1; page_type_d = 2'd2;
        send();
        chk_bin("pg_bin50", 50, 32'd1);
        write_access = 1'b0; order = 64'd9;
        send();
        chk_bin("pg_bin50_hold", 50, 32'd1);
        chk_all();

        // Randomized records, occasional order jumps.
        for (int n = 0; n < 40; n++) begin
            order = ($urandom_range(0, 4) == 0) ? m_prev + 64'($urandom_range(2, 9))
                                                : m_prev + 64'd1;
            insn = $urandom;
            trap = 1'($urandom_range(0, 1)); debug_mode = 1'($urandom_range(0, 1));
            pc_rdata = {$urandom, $urandom}; mode = 2'($urandom_range(0, 3));
            m_ext_intr = 1'($urandom_range(0, 1)); s_ext_intr = 1'($urandom_range(0, 1));
            m_timer_intr = 1'($urandom_range(0, 1)); m_soft_intr = 1'($urandom_range(0, 1));
            read_access = 1'($urandom_range(0, 1)); write_access = 1'($urandom_range(0, 1));
            execute_access = 1'($urandom_range(0, 1)); page_type_d = 2'($urandom_range(0, 3));
            x_wb = 32'd1 << $urandom_range(0, 31); f_wb = 32'd1 << $urandom_range(0, 31);
            v_wb = ($urandom_range(0, 3) == 0) ? 32'd1 : 32'd0;
            send();
            if (n % 7 == 3) idle(1);
        end
        chk_all();

        // Saturation on the narrow instance: 17 records, bin0 holds 15.
        do_reset(1'b0);
        clear_rec();
        for (int i = 1; i <= 17; i++) begin
            order = 64'(i);
            send();
        end
        cov_sel = 6'd0;
        #1;
        check_val("sat_small_bin0", {60'd0, s_cov_count}, 64'(m_small));
        check_val("sat_small_15", {60'd0, s_cov_count}, 64'd15);
        check_val("sat_big_bin0", {32'd0, cov_count}, 64'd17);

        // Reset together with valid, then a record at an arbitrary order.
        x_wb = 32'h0000_0003; order = 64'd500;
        do_reset(1'b1);
        chk_all();
        check_val("rv_x_seen", {32'd0, x_seen}, 64'd0);
        clear_rec();
        order = 64'd100; send();
        check_val("rv_no_err", {63'd0, order_err}, 64'd0);
        order = 64'd101; send();
        order = 64'hFFFF_FFFF_FFFF_FFFF; send();
        order = 64'd0; send();
        chk_bin("wrap_bin15", 15, 32'd1);
        chk_all();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
